cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have control inputs, each 1 bit: selPC (PC load source), loadIR, loadPC, incPC, loadacc, wr_en, rd_en.
REQ-004 SHALL have: selacc  input  2  accumulator source select.
REQ-005 SHALL have: alu_op  input  8  ALU operation code.
REQ-006 SHALL have: mem_rdata  input  32  memory read data, valid in the same cycle the address is presented.
REQ-007 SHALL have: mem_addr  output  16  memory address.
REQ-008 SHALL have: mem_wdata  output  32  memory write data.
REQ-009 SHALL have: mem_we  output  1  memory write strobe.
REQ-010 SHALL have: mem_re  output  1  memory read strobe.
REQ-011 SHALL have: opcode  output  8  IR[31:24], fed to the control unit.
REQ-012 SHALL have: z, c  output  1 each  zero and carry flags, fed to the control unit.
REQ-013 SHALL have: acc  output  32  and pc  output  16  architectural state visibility.

Function
REQ-014 Registers: PC[15:0], IR[31:0], ACC[31:0], Z, C; all outputs are registered or combinational from these registers plus control inputs.
REQ-015 Instruction word: opcode=IR[31:24], immediate=IR[23:0] zero-extended to 32 bits, address=IR[15:0].
REQ-016 mem_addr: PC when loadIR=1; otherwise IR[15:0].
REQ-017 mem_re = loadIR | (rd_en & ~wr_en); mem_we = wr_en; mem_wdata = ACC.
REQ-018 wr_en and rd_en both high: write takes priority, mem_re=0, mem_we=1.
REQ-019 loadIR=1: IR <= mem_rdata at the next edge.
REQ-020 loadPC=1: PC <= IR[15:0] when selPC=1; PC <= mem_rdata[15:0] when selPC=0.
REQ-021 incPC=1 and loadPC=0: PC <= PC+1, wrapping 16'hFFFF to 16'h0000.
REQ-022 loadPC and incPC both high: loadPC wins, no increment.
REQ-023 loadacc=1: ACC <= ALU result (selacc=00), immediate (01), mem_rdata (10), or hold (11).
REQ-024 ALU operand A=ACC, operand B=zero-extended immediate; ops: 01 add, 02 sub (A-B), 03 mul (low 32 bits), 05 not A, 06 or, 07 xor, 08 and, 09 shl A by 1, 0A shr A by 1 logical; any other code returns A.
REQ-025 Carry: add = bit 32 of 33-bit sum; sub = borrow (A<B); mul = 1 if upper 32 product bits nonzero; shl = old A[31]; shr = old A[0]; logical ops and default = 0.
REQ-026 Flags update only when loadacc=1 and selacc=00: Z <= (result==0), C per REQ-025; otherwise Z, C hold.
REQ-027 loadacc=0: ACC holds regardless of selacc and alu_op.
REQ-028 Any combination of loadIR, loadPC/incPC, loadacc in one cycle SHALL update each register independently in the same edge, each using pre-edge values.

Reset
REQ-029 rstn=0 SHALL immediately (without clock) force PC=0, IR=0, ACC=0, Z=0, C=0; hence opcode=0.
REQ-030 Reset asserted mid-instruction SHALL discard the in-flight operation; first edge after rstn rises uses reset state.
REQ-031 mem_we and mem_re SHALL follow control inputs only (combinational), so they are 0 during reset only if the control unit drives its strobes low.

Verification
REQ-032 Fetch: PC=0, mem_rdata=32'h01_000005, loadIR=1, incPC=1 -> IR=32'h01000005, opcode=8'h01, PC=1, mem_addr=0, mem_re=1.
REQ-033 Add with carry: ACC=32'hFFFFFFFF, IR imm=1, alu_op=01, selacc=00, loadacc=1 -> ACC=0, Z=1, C=1.
REQ-034 Jumps: IR[15:0]=16'h0040, loadPC=1 selPC=1 -> PC=16'h0040; then mem_rdata=32'h0000_1234, selPC=0, loadPC=1, incPC=1 -> PC=16'h1234 (no increment).
REQ-035 Memory: ACC=32'hDEADBEEF, IR[15:0]=16'h0010, wr_en=1 rd_en=1 -> mem_addr=16'h0010, mem_we=1, mem_re=0, mem_wdata=32'hDEADBEEF; selacc=10 rd_en=1 loadacc=1, mem_rdata=32'h00000000 -> ACC=0, Z and C unchanged.
REQ-036 Wrap and shifts: PC=16'hFFFF, incPC=1 -> PC=0; ACC=32'h80000001, alu_op=09 -> ACC=32'h00000002, C=1; alu_op=0A -> ACC=32'h00000001, C=0.
REQ-037 Async reset: assert rstn=0 between edges with ACC, PC, IR nonzero -> all zero before next edge; hold loadacc=1 through reset -> ACC stays 0.

Source files
------------

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//
// Accumulator-style CPU datapath. Holds the architectural registers PC, IR,
// ACC and the Z/C flags, contains the ALU and the memory address/strobe
// muxing. All sequencing decisions come from an external control unit
// through the one-bit control inputs below; this block only executes them.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rstn       in   1   asynchronous active-low reset
//   selPC      in   1   PC load source: 1 = IR[15:0], 0 = mem_rdata[15:0]
//   loadIR     in   1   IR <= mem_rdata; also routes PC onto mem_addr
//   loadPC     in   1   load PC (wins over incPC)
//   incPC      in   1   PC <= PC + 1
//   loadacc    in   1   load ACC from the source picked by selacc
//   wr_en      in   1   memory write request (wins over rd_en)
//   rd_en      in   1   memory read request
//   selacc     in   2   ACC source: 00 ALU, 01 immediate, 10 mem_rdata, 11 hold
//   alu_op     in   8   ALU operation code
//   mem_rdata  in  32   memory read data (same-cycle)
//   mem_addr   out 16   memory address
//   mem_wdata  out 32   memory write data (= ACC)
//   mem_we     out  1   memory write strobe
//   mem_re     out  1   memory read strobe
//   opcode     out  8   IR[31:24]
//   z, c       out  1   zero / carry flags
//   acc        out 32   accumulator
//   pc         out 16   program counter
// ---------------------------------------------------------------------------
module cpu_datapath (
    input  logic        clk,
    input  logic        rstn,
    input  logic        selPC,
    input  logic        loadIR,
    input  logic        loadPC,
    input  logic        incPC,
    input  logic        loadacc,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  selacc,
    input  logic [7:0]  alu_op,
    input  logic [31:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  opcode,
    output logic        z,
    output logic        c,
    output logic [31:0] acc,
    output logic [15:0] pc
);

    // ALU operation codes
    localparam logic [7:0] OpAdd = 8'h01;
    localparam logic [7:0] OpSub = 8'h02;
    localparam logic [7:0] OpMul = 8'h03;
    localparam logic [7:0] OpNot = 8'h05;
    localparam logic [7:0] OpOr  = 8'h06;
    localparam logic [7:0] OpXor = 8'h07;
    localparam logic [7:0] OpAnd = 8'h08;
    localparam logic [7:0] OpShl = 8'h09;
    localparam logic [7:0] OpShr = 8'h0A;

    // ACC source selects
    localparam logic [1:0] AccAlu  = 2'b00;
    localparam logic [1:0] AccImm  = 2'b01;
    localparam logic [1:0] AccMem  = 2'b10;

    // Architectural state
    logic [15:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_acc;
    logic        r_z;
    logic        r_c;

    // Next-state and ALU wires
    logic [15:0] w_pc_d;
    logic [31:0] w_ir_d;
    logic [31:0] w_acc_d;
    logic        w_z_d;
    logic        w_c_d;

    logic [31:0] w_imm;
    logic [32:0] w_sum;
    logic [31:0] w_diff;
    logic [63:0] w_prod;
    logic [31:0] w_alu_res;
    logic        w_alu_cy;
    logic        w_flag_upd;

    // Immediate is the low 24 bits of IR, zero-extended
    assign w_imm  = {8'h00, r_ir[23:0]};

    assign w_sum  = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_diff = r_acc - w_imm;
    assign w_prod = {32'h0000_0000, r_acc} * {32'h0000_0000, w_imm};

    // ------------------------------------------------------------------
    // ALU: operand A = ACC, operand B = immediate
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_res = r_acc;
        w_alu_cy  = 1'b0;
        case (alu_op)
            OpAdd: begin
                w_alu_res = w_sum[31:0];
                w_alu_cy  = w_sum[32];
            end
            OpSub: begin
                w_alu_res = w_diff;
                w_alu_cy  = (r_acc < w_imm);      // borrow
            end
            OpMul: begin
                w_alu_res = w_prod[31:0];
                w_alu_cy  = |w_prod[63:32];       // product overflowed 32 bits
            end
            OpNot: w_alu_res = ~r_acc;
            OpOr:  w_alu_res = r_acc | w_imm;
            OpXor: w_alu_res = r_acc ^ w_imm;
            OpAnd: w_alu_res = r_acc & w_imm;
            OpShl: begin
                w_alu_res = {r_acc[30:0], 1'b0};
                w_alu_cy  = r_acc[31];
            end
            OpShr: begin
                w_alu_res = {1'b0, r_acc[31:1]};
                w_alu_cy  = r_acc[0];
            end
            default: begin
                w_alu_res = r_acc;
                w_alu_cy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic; every register sees only pre-edge values so any
    // mix of loadIR / loadPC / incPC / loadacc can share one edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_ir_d = r_ir;
        if (loadIR) begin
            w_ir_d = mem_rdata;
        end
    end

    always_comb begin
        w_pc_d = r_pc;
        if (loadPC) begin
            w_pc_d = selPC ? r_ir[15:0] : mem_rdata[15:0];
        end else if (incPC) begin
            w_pc_d = r_pc + 16'd1;                // wraps naturally at 16 bits
        end
    end

    assign w_flag_upd = loadacc && (selacc == AccAlu);

    always_comb begin
        w_acc_d = r_acc;
        if (loadacc) begin
            case (selacc)
                AccAlu:  w_acc_d = w_alu_res;
                AccImm:  w_acc_d = w_imm;
                AccMem:  w_acc_d = mem_rdata;
                default: w_acc_d = r_acc;
            endcase
        end
    end

    always_comb begin
        w_z_d = r_z;
        w_c_d = r_c;
        if (w_flag_upd) begin
            w_z_d = (w_alu_res == 32'h0000_0000);
            w_c_d = w_alu_cy;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc  <= 16'h0000;
            r_ir  <= 32'h0000_0000;
            r_acc <= 32'h0000_0000;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
        end else begin
            r_pc  <= w_pc_d;
            r_ir  <= w_ir_d;
            r_acc <= w_acc_d;
            r_z   <= w_z_d;
            r_c   <= w_c_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory interface; strobes are purely combinational from controls,
    // write request masks the read strobe.
    // ------------------------------------------------------------------
    assign mem_addr  = loadIR ? r_pc : r_ir[15:0];
    assign mem_re    = loadIR | (rd_en & ~wr_en);
    assign mem_we    = wr_en;
    assign mem_wdata = r_acc;

    // Architectural visibility
    assign opcode = r_ir[31:24];
    assign z      = r_z;
    assign c      = r_c;
    assign acc    = r_acc;
    assign pc     = r_pc;

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath
//
// Self-checking bench: directed scenarios for the documented examples, then
// randomized control/data traffic, all checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_cpu_datapath;

    logic        clk;
    logic        rstn;
    logic        selPC, loadIR, loadPC, incPC, loadacc, wr_en, rd_en;
    logic [1:0]  selacc;
    logic [7:0]  alu_op;
    logic [31:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  opcode;
    logic        z, c;
    logic [31:0] acc;
    logic [15:0] pc;

    int n_checks;
    int n_fails;

    // Reference model state
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_acc;
    logic        m_z;
    logic        m_c;

    // Combinational observations from the last step
    logic [15:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic        obs_re;

    cpu_datapath u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .selPC     (selPC),
        .loadIR    (loadIR),
        .loadPC    (loadPC),
        .incPC     (incPC),
        .loadacc   (loadacc),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .selacc    (selacc),
        .alu_op    (alu_op),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .opcode    (opcode),
        .z         (z),
        .c         (c),
        .acc       (acc),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU from the operation table: returns {carry, result}
    function automatic logic [32:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned la, lb, r;
        logic [63:0] v;
        la = longint'(a);
        lb = longint'(b);
        case (op)
            8'h01: begin r = la + lb; v = r; return {v[32], v[31:0]}; end
            8'h02: return {(a < b), a - b};
            8'h03: begin r = la * lb; v = r; return {(v[63:32] != 0), v[31:0]}; end
            8'h05: return {1'b0, ~a};
            8'h06: return {1'b0, a | b};
            8'h07: return {1'b0, a ^ b};
            8'h08: return {1'b0, a & b};
            8'h09: return {a[31], a << 1};
            8'h0A: return {a[0], a >> 1};
            default: return {1'b0, a};
        endcase
    endfunction

    task automatic model_reset();
        m_pc  = '0;
        m_ir  = '0;
        m_acc = '0;
        m_z   = 1'b0;
        m_c   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"}, 64'(pc), 64'(m_pc));
        check({tag, ".opcode"}, 64'(opcode), 64'(m_ir[31:24]));
        check({tag, ".acc"}, 64'(acc), 64'(m_acc));
        check({tag, ".z"}, 64'(z), 64'(m_z));
        check({tag, ".c"}, 64'(c), 64'(m_c));
    endtask

    // One cycle: called just after a falling edge, returns after the next one.
    task automatic step(input string tag, input logic sp, input logic lir, input logic lpc,
                        input logic ipc, input logic lacc, input logic we, input logic re,
                        input logic [1:0] sa, input logic [7:0] op, input logic [31:0] rd);
        logic [32:0] alu;
        logic [31:0] imm;
        selPC = sp; loadIR = lir; loadPC = lpc; incPC = ipc; loadacc = lacc;
        wr_en = we; rd_en = re; selacc = sa; alu_op = op; mem_rdata = rd;
        #1;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we; obs_re = mem_re;
        check({tag, ".mem_addr"}, 64'(mem_addr), 64'(lir ? m_pc : m_ir[15:0]));
        check({tag, ".mem_re"}, 64'(mem_re), 64'(lir || (re && !we)));
        check({tag, ".mem_we"}, 64'(mem_we), 64'(we));
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(m_acc));
        @(posedge clk);
        imm = {8'h00, m_ir[23:0]};
        alu = ref_alu(op, m_acc, imm);
        if (lpc)      m_pc = sp ? m_ir[15:0] : rd[15:0];
        else if (ipc) m_pc = 16'((int'(m_pc) + 1) % 65536);
        if (lacc) begin
            if (sa == 2'b00) begin
                m_acc = alu[31:0];
                m_z   = (alu[31:0] == 0);
                m_c   = alu[32];
            end else if (sa == 2'b01) begin
                m_acc = imm;
            end else if (sa == 2'b10) begin
                m_acc = rd;
            end
        end
        if (lir) m_ir = rd;
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ops [12];
        n_checks = 0;
        n_fails  = 0;
        ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                8'h00, 8'h04, 8'hFF};
        selPC = 0; loadIR = 0; loadPC = 0; incPC = 0; loadacc = 0;
        wr_en = 0; rd_en = 0; selacc = 0; alu_op = 0; mem_rdata = 0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Fetch
        step("fetch", 0, 1, 0, 1, 0, 0, 0, 2'b00, 8'h00, 32'h0100_0005);
        check("fetch.addr_lit", 64'(obs_addr), 64'h0);
        check("fetch.re_lit", 64'(obs_re), 64'h1);
        check("fetch.opcode_lit", 64'(opcode), 64'h01);
        check("fetch.pc_lit", 64'(pc), 64'h1);

        // Add with carry out to zero
        step("ldacc", 0, 0, 0, 0, 1, 0, 1, 2'b10, 8'h00, 32'hFFFF_FFFF);
        step("ldir1", 0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0000_0001);
        step("add", 0, 0, 0, 0, 1, 0, 0, 2'b00, 8'h01, 32'h0);
        check("add.acc_lit", 64'(acc), 64'h0);
        check("add.z_lit", 64'(z), 64'h1);
        check("add.c_lit", 64'(c), 64'h1);

        // Jumps
        step("ldir40", 0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0000_0040);
        step("jmp_ir", 1, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0);
        check("jmp_ir.pc_lit", 64'(pc), 64'h0040);
        step("jmp_mem", 0, 0, 1, 1, 0, 0, 0, 2'b00, 8'h00, 32'h0000_1234);
        check("jmp_mem.pc_lit", 64'(pc), 64'h1234);

        // Memory write priority, then load from memory leaves flags alone
        step("ldbeef", 0, 0, 0, 0, 1, 0, 1, 2'b10, 8'h00, 32'hDEAD_BEEF);
        step("ldir10", 0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0000_0010);
        step("wr", 0, 0, 0, 0, 0, 1, 1, 2'b00, 8'h00, 32'h0);
        check("wr.addr_lit", 64'(obs_addr), 64'h0010);
        check("wr.we_lit", 64'(obs_we), 64'h1);
        check("wr.re_lit", 64'(obs_re), 64'h0);
        check("wr.wdata_lit", 64'(obs_wdata), 64'hDEAD_BEEF);
        step("rdmem", 0, 0, 0, 0, 1, 0, 1, 2'b10, 8'h00, 32'h0);
        check("rdmem.acc_lit", 64'(acc), 64'h0);
        check("rdmem.z_held", 64'(z), 64'h1);
        check("rdmem.c_held", 64'(c), 64'h1);

        // PC wrap and shifts
        step("ldirff", 0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0000_FFFF);
        step("jmpff", 1, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0);
        step("wrap", 0, 0, 0, 1, 0, 0, 0, 2'b00, 8'h00, 32'h0);
        check("wrap.pc_lit", 64'(pc), 64'h0);
        step("ld8001", 0, 0, 0, 0, 1, 0, 0, 2'b10, 8'h00, 32'h8000_0001);
        step("shl", 0, 0, 0, 0, 1, 0, 0, 2'b00, 8'h09, 32'h0);
        check("shl.acc_lit", 64'(acc), 64'h2);
        check("shl.c_lit", 64'(c), 64'h1);
        step("shr", 0, 0, 0, 0, 1, 0, 0, 2'b00, 8'h0A, 32'h0);
        check("shr.acc_lit", 64'(acc), 64'h1);
        check("shr.c_lit", 64'(c), 64'h0);

        // Asynchronous reset between edges with loadacc held high
        step("ldpc", 0, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 32'h0000_ABCD);
        loadacc = 1'b1; selacc = 2'b10; mem_rdata = 32'h1234_5678;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge clk);
        #1;
        check("rst_hold.acc", 64'(acc), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rd;
            logic [1:0]  rsel;
            rsel = 2'($urandom_range(0, 3));
            case (rsel)
                2'd0: rd = $urandom;
                2'd1: rd = $urandom_range(0, 255);
                2'd2: rd = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: rd = {$urandom_range(0, 15) == 0 ? 8'h00 : 8'($urandom), 24'($urandom)};
            endcase
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), ops[$urandom_range(0, 11)], rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
